// File: rtl/fsm_seq_ctrl_if.sv
// fsm_seq_ctrl_if: decoder/memory handshake and control-enable bundle for the sequencer
interface fsm_seq_ctrl_if #(parameter int OPND_W = 2);
  logic              start;
  logic              inst_available;
  logic              halt;
  logic              mem_ready;
  logic [2:0]        opclass;
  logic [OPND_W-1:0] operand_len;
  logic              branch_taken;
  logic [3:0]        state;
  logic              read_en;
  logic              write_en;
  logic              pc_en;
  logic              pc_load;
  logic              ir_en;
  logic              opnd_en;
  logic [OPND_W-1:0] opnd_idx;
  logic              load_dp_out;
  logic              execute_en;
  logic              inst_mem_en;
  logic              busy;
  logic              fault;
  modport master (
    output start, inst_available, halt, mem_ready, opclass, operand_len, branch_taken,
    input  state, read_en, write_en, pc_en, pc_load, ir_en, opnd_en, opnd_idx,
           load_dp_out, execute_en, inst_mem_en, busy, fault
  );
  modport slave (
    input  start, inst_available, halt, mem_ready, opclass, operand_len, branch_taken,
    output state, read_en, write_en, pc_en, pc_load, ir_en, opnd_en, opnd_idx,
           load_dp_out, execute_en, inst_mem_en, busy, fault
  );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: instruction-control sequencer with operand fetch, memory wait/timeout, branch and halt
module fsm_seq_ctrl #(
  parameter int OPND_W      = 2,
  parameter int OPERAND_MAX = 2,
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clka,
  input logic            restart,
  fsm_seq_ctrl_if.slave  io_bus
);
  typedef enum logic [3:0] {
    S_IDLE = 4'h0, S_FETCH = 4'h1, S_DECODE = 4'h2, S_OPND_PC = 4'h3,
    S_OPND_FETCH = 4'h4, S_BRANCH = 4'h5, S_STORE = 4'h6, S_LOAD = 4'h7,
    S_LOAD_ALU = 4'h8, S_EXECUTE = 4'h9, S_PC_INC = 4'hA, S_FAULT = 4'hB,
    S_INST_WAIT = 4'hC, S_INST_WRITE = 4'hD
  } state_t;
  state_t            r_state, w_next, w_stall;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [OPND_W-1:0] r_opnd_idx, r_remaining;
  logic [2:0]        r_class;
  logic              w_mem, w_timeout, w_illegal;
  function automatic state_t f_dispatch(input logic [2:0] c);
    case (c)
      3'd0:    return S_INST_WAIT;
      3'd1:    return S_LOAD;
      3'd2:    return S_STORE;
      3'd3:    return S_BRANCH;
      3'd4:    return S_EXECUTE;
      3'd5:    return S_LOAD_ALU;
      default: return S_FAULT;
    endcase
  endfunction
  assign w_mem     = r_state inside {S_FETCH, S_OPND_FETCH, S_LOAD, S_STORE, S_LOAD_ALU};
  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign w_stall   = w_timeout ? S_FAULT : r_state;
  assign w_illegal = (io_bus.opclass >= 3'd6) || (io_bus.operand_len > OPND_W'(OPERAND_MAX));
  // next-state selection; restart wins over every other input
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INST_WAIT:  w_next = io_bus.inst_available ? S_INST_WRITE : io_bus.start ? S_IDLE : S_INST_WAIT;
      S_INST_WRITE: w_next = io_bus.inst_available ? S_INST_WRITE : S_INST_WAIT;
      S_IDLE:       w_next = io_bus.halt ? S_IDLE : S_PC_INC;
      S_PC_INC:     w_next = S_FETCH;
      S_FETCH:      w_next = io_bus.mem_ready ? S_DECODE : w_stall;
      S_DECODE:     w_next = w_illegal ? S_FAULT : (io_bus.operand_len != '0) ? S_OPND_PC : f_dispatch(io_bus.opclass);
      S_OPND_PC:    w_next = S_OPND_FETCH;
      S_OPND_FETCH: w_next = io_bus.mem_ready ? ((r_remaining == OPND_W'(1)) ? f_dispatch(r_class) : S_OPND_PC) : w_stall;
      S_LOAD:       w_next = io_bus.mem_ready ? S_IDLE : w_stall;
      S_STORE:      w_next = io_bus.mem_ready ? S_IDLE : w_stall;
      S_LOAD_ALU:   w_next = io_bus.mem_ready ? S_EXECUTE : w_stall;
      S_EXECUTE:    w_next = S_IDLE;
      S_BRANCH:     w_next = S_IDLE;
      default:      w_next = S_FAULT;
    endcase
    if (restart) w_next = S_INST_WAIT;
  end
  // state register
  always_ff @(posedge clka) begin
    r_state <= w_next;
  end
  // wait counter, operand bookkeeping and latched instruction class
  always_ff @(posedge clka) begin
    if (restart) begin
      r_wait_cnt  <= '0;
      r_opnd_idx  <= '0;
      r_remaining <= '0;
      r_class     <= '0;
    end else begin
      r_wait_cnt <= (w_next != r_state) ? '0 : (w_mem && !io_bus.mem_ready) ? r_wait_cnt + 1'b1 : r_wait_cnt;
      if (r_state == S_DECODE) begin
        r_class     <= io_bus.opclass;
        r_remaining <= io_bus.operand_len;
        r_opnd_idx  <= '0;
      end else if (r_state == S_OPND_FETCH && io_bus.mem_ready) begin
        r_opnd_idx  <= r_opnd_idx + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end
  assign io_bus.state       = r_state;
  assign io_bus.read_en     = r_state inside {S_FETCH, S_OPND_FETCH, S_LOAD, S_LOAD_ALU};
  assign io_bus.write_en    = r_state == S_STORE;
  assign io_bus.pc_en       = r_state inside {S_PC_INC, S_OPND_PC};
  assign io_bus.pc_load     = (r_state == S_BRANCH) && io_bus.branch_taken;
  assign io_bus.ir_en       = (r_state == S_FETCH) && io_bus.mem_ready;
  assign io_bus.opnd_en     = (r_state == S_OPND_FETCH) && io_bus.mem_ready;
  assign io_bus.opnd_idx    = (r_state == S_INST_WAIT) ? '0 : r_opnd_idx;
  assign io_bus.load_dp_out = (r_state == S_LOAD) && io_bus.mem_ready;
  assign io_bus.execute_en  = r_state == S_EXECUTE;
  assign io_bus.inst_mem_en = r_state == S_INST_WRITE;
  assign io_bus.busy        = !(r_state inside {S_INST_WAIT, S_IDLE, S_FAULT});
  assign io_bus.fault       = r_state == S_FAULT;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: directed scenario tests for the instruction-control sequencer
module tb_fsm_seq_ctrl;
  logic clka = 1'b0;
  logic restart;
  int   err = 0;
  int   chk = 0;
  logic [10:0] w_outs;
  fsm_seq_ctrl_if #(.OPND_W(2)) bus ();
  fsm_seq_ctrl #(.OPND_W(2), .OPERAND_MAX(2), .WAIT_W(4), .MEM_TIMEOUT(3)) dut (
    .clka(clka), .restart(restart), .io_bus(bus.slave)
  );
  always #5 clka = ~clka;
  assign w_outs = {bus.read_en, bus.write_en, bus.pc_en, bus.pc_load, bus.ir_en, bus.opnd_en,
                   bus.load_dp_out, bus.execute_en, bus.inst_mem_en, bus.busy, bus.fault};
  task automatic tick;
    @(posedge clka);
    #1;
  endtask
  task automatic go_idle;
    bus.inst_available = 0;
    restart = 1;
    tick();
    restart = 0;
    bus.halt = 1;
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  task automatic test_reset;
    restart = 1;
    tick();
    tick();
    restart = 0;
    chk++; if (bus.state !== 4'hC) begin err++; $display("FAIL reset_state got %h exp %h", bus.state, 4'hC); end
    chk++; if (w_outs !== 11'd0) begin err++; $display("FAIL reset_outs got %b exp %b", w_outs, 11'd0); end
    chk++; if (bus.opnd_idx !== 2'd0) begin err++; $display("FAIL reset_idx got %0d exp 0", bus.opnd_idx); end
    tick();
    chk++; if (bus.state !== 4'hC) begin err++; $display("FAIL reset_hold got %h exp %h", bus.state, 4'hC); end
  endtask
  task automatic test_inst_load;
    logic [3:0] es [6] = '{4'hC, 4'hD, 4'hD, 4'hD, 4'hC, 4'h0};
    logic       ia [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       st [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int n = 0;
    bus.halt = 1;
    for (int i = 0; i < 6; i++) begin
      bus.inst_available = ia[i];
      bus.start = st[i];
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL inst_load_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      n += int'(bus.inst_mem_en);
      tick();
    end
    bus.start = 0;
    chk++; if (n !== 3) begin err++; $display("FAIL inst_mem_en_cycles got %0d exp 3", n); end
    chk++; if (bus.state !== 4'h0) begin err++; $display("FAIL inst_load_idle got %h exp 0", bus.state); end
  endtask
  task automatic test_load_wait;
    logic [3:0] es [18] = '{4'h0, 4'hA, 4'h1, 4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h4,
                            4'h4, 4'h3, 4'h4, 4'h4, 4'h4, 4'h7, 4'h7, 4'h7, 4'h0};
    logic [17:0] mrv = 18'h12210;
    int npc = 0, nop = 0, nld = 0;
    bus.opclass = 3'd1;
    bus.operand_len = 2'd2;
    for (int i = 0; i < 18; i++) begin
      bus.halt = (i != 0);
      bus.mem_ready = mrv[i];
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL load_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      chk++; if (bus.read_en !== (es[i] inside {4'h1, 4'h4, 4'h7, 4'h8})) begin err++; $display("FAIL load_read_en[%0d] got %b", i, bus.read_en); end
      if (bus.opnd_en) begin
        chk++; if (bus.opnd_idx !== 2'(nop)) begin err++; $display("FAIL load_opnd_idx got %0d exp %0d", bus.opnd_idx, nop); end
        nop++;
      end
      npc += int'(bus.pc_en);
      nld += int'(bus.load_dp_out);
      tick();
    end
    chk++; if (npc !== 3) begin err++; $display("FAIL load_pc_en got %0d exp 3", npc); end
    chk++; if (nop !== 2) begin err++; $display("FAIL load_opnd_en got %0d exp 2", nop); end
    chk++; if (nld !== 1) begin err++; $display("FAIL load_dp_out got %0d exp 1", nld); end
  endtask
  task automatic test_branch(input logic tk);
    logic [3:0] es [8] = '{4'h0, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0};
    int npl = 0;
    bus.opclass = 3'd3;
    bus.operand_len = 2'd1;
    bus.branch_taken = tk;
    bus.mem_ready = 1;
    for (int i = 0; i < 8; i++) begin
      bus.halt = (i != 0);
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL branch%0d_state[%0d] got %h exp %h", tk, i, bus.state, es[i]); end
      npl += int'(bus.pc_load);
      tick();
    end
    chk++; if (npl !== int'(tk)) begin err++; $display("FAIL branch%0d_pc_load got %0d exp %0d", tk, npl, tk); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] es [11] = '{4'h0, 4'hA, 4'h1, 4'h2, 4'h9, 4'h0, 4'hA, 4'h1, 4'h2, 4'h9, 4'h0};
    int nex = 0;
    bus.opclass = 3'd4;
    bus.operand_len = 2'd0;
    bus.mem_ready = 1;
    for (int i = 0; i < 11; i++) begin
      bus.halt = (i == 10);
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL b2b_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      nex += int'(bus.execute_en);
      tick();
    end
    chk++; if (nex !== 2) begin err++; $display("FAIL b2b_execute_en got %0d exp 2", nex); end
  endtask
  task automatic test_timeout;
    logic [3:0] es [7] = '{4'h0, 4'hA, 4'h1, 4'h1, 4'h1, 4'h1, 4'hB};
    bus.opclass = 3'd4;
    bus.operand_len = 2'd0;
    bus.mem_ready = 0;
    for (int i = 0; i < 7; i++) begin
      bus.halt = (i != 0);
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL timeout_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      if (i < 6) tick();
    end
    chk++; if (w_outs !== 11'b1) begin err++; $display("FAIL timeout_outs got %b exp %b", w_outs, 11'b1); end
    bus.start = 1;
    bus.inst_available = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk++; if (bus.state !== 4'hB || bus.fault !== 1'b1) begin err++; $display("FAIL fault_sticky[%0d] got %h/%b exp b/1", i, bus.state, bus.fault); end
    end
    bus.start = 0;
    bus.inst_available = 0;
    restart = 1;
    tick();
    restart = 0;
    chk++; if (bus.state !== 4'hC || bus.fault !== 1'b0) begin err++; $display("FAIL fault_clear got %h/%b exp c/0", bus.state, bus.fault); end
  endtask
  task automatic test_illegal;
    logic [3:0] es [5] = '{4'h0, 4'hA, 4'h1, 4'h2, 4'hB};
    logic [2:0] oc [2] = '{3'd7, 3'd1};
    logic [1:0] ol [2] = '{2'd0, 2'd3};
    bus.mem_ready = 1;
    for (int k = 0; k < 2; k++) begin
      go_idle();
      bus.opclass = oc[k];
      bus.operand_len = ol[k];
      for (int i = 0; i < 5; i++) begin
        bus.halt = (i != 0);
        #1;
        chk++; if (bus.state !== es[i]) begin err++; $display("FAIL illegal%0d_state[%0d] got %h exp %h", k, i, bus.state, es[i]); end
        if (i < 4) tick();
      end
      chk++; if (bus.fault !== 1'b1) begin err++; $display("FAIL illegal%0d_fault got %b exp 1", k, bus.fault); end
    end
  endtask
  task automatic test_noop;
    logic [3:0] es [7] = '{4'h0, 4'hA, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC};
    go_idle();
    bus.opclass = 3'd0;
    bus.operand_len = 2'd1;
    bus.mem_ready = 1;
    for (int i = 0; i < 7; i++) begin
      bus.halt = (i != 0);
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL noop_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      if (i < 6) tick();
    end
    chk++; if (w_outs !== 11'd0 || bus.opnd_idx !== 2'd0) begin err++; $display("FAIL noop_wait_outs got %b/%0d exp 0/0", w_outs, bus.opnd_idx); end
  endtask
  task automatic test_halt_reset;
    logic [3:0] es [6] = '{4'h0, 4'hA, 4'h1, 4'h2, 4'h6, 4'h6};
    go_idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk++; if (bus.state !== 4'h0 || bus.busy !== 1'b0) begin err++; $display("FAIL halt_hold[%0d] got %h/%b exp 0/0", i, bus.state, bus.busy); end
    end
    bus.opclass = 3'd2;
    bus.operand_len = 2'd0;
    for (int i = 0; i < 6; i++) begin
      bus.halt = (i != 0);
      bus.mem_ready = (i == 2);
      #1;
      chk++; if (bus.state !== es[i]) begin err++; $display("FAIL store_state[%0d] got %h exp %h", i, bus.state, es[i]); end
      if (i < 5) tick();
    end
    chk++; if (bus.write_en !== 1'b1) begin err++; $display("FAIL store_write_en got %b exp 1", bus.write_en); end
    restart = 1;
    tick();
    restart = 0;
    chk++; if (bus.state !== 4'hC || bus.write_en !== 1'b0) begin err++; $display("FAIL midop_reset got %h/%b exp c/0", bus.state, bus.write_en); end
  endtask
  initial begin
    restart = 1;
    bus.start = 0;
    bus.inst_available = 0;
    bus.halt = 1;
    bus.mem_ready = 0;
    bus.opclass = 3'd0;
    bus.operand_len = 2'd0;
    bus.branch_taken = 0;
    test_reset();
    test_inst_load();
    test_load_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_noop();
    test_halt_reset();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule

// File: doc/fsm_seq_ctrl.md
Name: fsm_seq_ctrl

Overview:
- Parametrised single-clock control sequencer for the 6502-style core; the next generation of the instruction-control FSM.
- Adds variable-length instruction fetch (0..OPERAND_MAX operand bytes), memory wait-state handshake with timeout fault, taken/not-taken branch, and halt.
- Sits between the instruction decoder (opclass, operand_len, branch_taken) and the datapath, PC and memory enables.

Parameters:
- OPND_W, 2: width of operand_len and opnd_idx.
- OPERAND_MAX, 2: maximum legal operand bytes per instruction; must be ≤ 2^OPND_W − 1.
- WAIT_W, 4: width of the memory wait counter.
- MEM_TIMEOUT, 15: wait cycles allowed before FAULT; 0 disables the timeout. Must be < 2^WAIT_W.

Ports:
- clka  in  1  system clock; all state updates on rising edge.
- restart  in  1  synchronous active-high reset.
- start  in  1  leave instruction-load mode and begin execution.
- inst_available  in  1  instruction-memory write data present.
- halt  in  1  hold in IDLE while high.
- mem_ready  in  1  data memory completes the current access this cycle.
- opclass  in  3  decoded class: 0 noop, 1 load, 2 store, 3 branch, 4 arithImmediate, 5 arithMemory, 6/7 illegal.
- operand_len  in  OPND_W  operand bytes following the opcode.
- branch_taken  in  1  branch condition result; sampled in BRANCH.
- state  out  4  current state encoding.
- read_en  out  1  data memory read request.
- write_en  out  1  data memory write request.
- pc_en  out  1  PC increment.
- pc_load  out  1  load PC from branch target.
- ir_en  out  1  capture opcode into IR.
- opnd_en  out  1  capture operand byte at opnd_idx.
- opnd_idx  out  OPND_W  operand byte index.
- load_dp_out  out  1  load result to datapath.
- execute_en  out  1  ALU execute strobe.
- inst_mem_en  out  1  instruction memory write enable.
- busy  out  1  high in every state except INST_WAIT, IDLE and FAULT.
- fault  out  1  sticky error flag.

Behaviour:
- Clocking and reset: all outputs are Moore decodes of the registered state plus mem_ready and branch_taken; no output is registered separately. restart has priority over every other input: next state INST_WAIT, wait_cnt=0, opnd_idx=0, remaining=0, latched class=0. In INST_WAIT every output is 0 and state=4'hC.
- State encodings: IDLE 0, FETCH 1, DECODE 2, OPND_PC 3, OPND_FETCH 4, BRANCH 5, STORE 6, LOAD 7, LOAD_ALU 8, EXECUTE 9, PC_INC A, FAULT B, INST_WAIT C, INST_WRITE D.
- INST_WAIT: if inst_available, go to INST_WRITE; else if start, go to IDLE; else stay.
- INST_WRITE: inst_mem_en=1. Stay while inst_available, else go to INST_WAIT.
- IDLE: if halt, stay; else go to PC_INC.
- PC_INC: pc_en=1 for one cycle, then FETCH.
- Memory states (FETCH, OPND_FETCH, LOAD, STORE, LOAD_ALU):
  - The request (read_en or write_en) is held high every cycle of the state.
  - Completion occurs in the cycle mem_ready=1; wait_cnt clears on exit.
  - Each cycle with mem_ready=0, wait_cnt increments. If MEM_TIMEOUT≠0, mem_ready=0 and wait_cnt==MEM_TIMEOUT, go to FAULT.
  - Minimum latency is 1 cycle.
- FETCH: ir_en = mem_ready; on completion go to DECODE.
- DECODE (one cycle):
  - Latch opclass into class_q; load remaining=operand_len; opnd_idx=0.
  - If opclass≥6 or operand_len>OPERAND_MAX, go to FAULT.
  - Else if operand_len>0, go to OPND_PC.
  - Else dispatch on opclass.
- OPND_PC: pc_en=1, then OPND_FETCH.
- OPND_FETCH: opnd_en = mem_ready. On completion, opnd_idx increments and remaining decrements. If remaining was 1, dispatch on class_q; else go to OPND_PC.
- Dispatch:
  - noop: INST_WAIT.
  - load: LOAD.
  - store: STORE.
  - branch: BRANCH.
  - arithImmediate: EXECUTE.
  - arithMemory: LOAD_ALU.
- LOAD: load_dp_out = mem_ready; on completion go to IDLE.
- STORE: on completion go to IDLE.
- LOAD_ALU: on completion go to EXECUTE.
- EXECUTE: execute_en=1 for one cycle, then IDLE.
- BRANCH: pc_load = branch_taken for one cycle, then IDLE.
- FAULT: fault=1 and every other enable is 0. Stays in FAULT until restart; start and inst_available are ignored.
- Simultaneous events:
  - restart overrides everything.
  - mem_ready in the same cycle the timeout would trigger counts as completion, not a fault.
  - halt is only sampled in IDLE.
- Ops-level timing: a 0-operand arithImmediate takes PC_INC, FETCH, DECODE, EXECUTE, IDLE, i.e. 5 cycles from IDLE to IDLE with mem_ready always 1. Each operand byte adds 2 cycles.

Test Plan:
- Instruction load: restart; inst_available=1 for 3 cycles, then start=1 → states C,D,D,D,C,0; inst_mem_en high exactly 3 cycles.
- Load with wait states: opclass=1, operand_len=2, mem_ready low 2 cycles in each memory state → pc_en pulses 3 times; opnd_en with opnd_idx 0 then 1; load_dp_out 1 cycle; returns to IDLE.
- Branch: opclass=3, operand_len=1. With branch_taken=1, pc_load pulses once in BRANCH. With branch_taken=0, pc_load stays 0; both cases go to IDLE.
- Timeout: MEM_TIMEOUT=3, mem_ready held 0 in FETCH → FAULT after 4 FETCH cycles, fault=1 sticky. start is ignored; restart returns the FSM to INST_WAIT.
- Illegal decode: opclass=7 → FAULT. Separately, operand_len=3 with OPERAND_MAX=2 → FAULT.
- Halt and mid-op reset: halt=1 in IDLE holds the FSM there for 5 cycles. restart asserted during STORE wait → next state INST_WAIT and write_en drops the same cycle.
